// File: rtl/alarme_pkg.sv
// Shared types and helpers for the alarm controller.
package alarme_pkg;

  typedef enum logic [2:0] {
    S_DISARMED = 3'd0,
    S_EXIT     = 3'd1,
    S_ARMED    = 3'd2,
    S_ENTRY    = 3'd3,
    S_ALARM    = 3'd4
  } estado_t;

  // Timer width: enough bits for the longest timed state, plus one.
  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/alarme_debounce.sv
// Two-flop synchronizer followed by a stability counter for one sensor.
module alarme_debounce #(
  parameter int unsigned DEB_CYCLES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);

  localparam int unsigned DW = $clog2(DEB_CYCLES) + 1;

  logic          sync1;
  logic          sync2;
  logic [DW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      // Count consecutive synchronized samples that disagree with the level.
      if (sync2 != level) begin
        if (cnt == DW'(DEB_CYCLES - 1)) begin
          level <= sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + DW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/alarme_ctrl.sv
// Arm/disarm controller with exit delay, entry delay and timed siren.
module alarme_ctrl
  import alarme_pkg::*;
#(
  parameter int unsigned EXIT_CYCLES  = 10,
  parameter int unsigned ENTRY_CYCLES = 8,
  parameter int unsigned SIREN_CYCLES = 20,
  parameter int unsigned DEB_CYCLES   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       arm,
  input  logic       disarm,
  input  logic       janela,
  input  logic       porta,
  output logic       sirene,
  output logic       aviso,
  output logic       armado,
  output logic       memoria,
  output logic       arm_erro,
  output logic [2:0] estado
);

  localparam int unsigned CW = cnt_width(EXIT_CYCLES, ENTRY_CYCLES, SIREN_CYCLES);

  logic          jan_deb;
  logic          por_deb;
  estado_t       state;
  estado_t       nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          erro_nxt;
  logic          mem_nxt;

  alarme_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_janela (
    .clk   (clk),
    .rst   (rst),
    .raw   (janela),
    .level (jan_deb)
  );

  alarme_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_porta (
    .clk   (clk),
    .rst   (rst),
    .raw   (porta),
    .level (por_deb)
  );

  // Next state and timer; disarm always takes priority.
  always_comb begin
    nxt      = state;
    cnt_nxt  = '0;
    erro_nxt = 1'b0;
    case (state)
      S_DISARMED: begin
        if (!disarm && arm) begin
          if (jan_deb || por_deb) begin
            erro_nxt = 1'b1;
          end else begin
            nxt     = S_EXIT;
            cnt_nxt = CW'(EXIT_CYCLES - 1);
          end
        end
      end
      S_EXIT: begin
        if (disarm)          nxt = S_DISARMED;
        else if (cnt == '0)  nxt = S_ARMED;
        else                 cnt_nxt = cnt - CW'(1);
      end
      S_ARMED: begin
        if (disarm) begin
          nxt = S_DISARMED;
        end else if (jan_deb) begin
          nxt     = S_ALARM;
          cnt_nxt = CW'(SIREN_CYCLES - 1);
        end else if (por_deb) begin
          nxt     = S_ENTRY;
          cnt_nxt = CW'(ENTRY_CYCLES - 1);
        end
      end
      S_ENTRY: begin
        if (disarm) begin
          nxt = S_DISARMED;
        end else if (jan_deb || cnt == '0) begin
          nxt     = S_ALARM;
          cnt_nxt = CW'(SIREN_CYCLES - 1);
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      S_ALARM: begin
        if (disarm)          nxt = S_DISARMED;
        else if (cnt == '0)  nxt = S_ARMED;
        else                 cnt_nxt = cnt - CW'(1);
      end
      default: nxt = S_DISARMED;
    endcase
  end

  // Alarm memory survives the return to ARMED and clears only on disarm.
  always_comb begin
    mem_nxt = memoria;
    if (nxt == S_DISARMED)   mem_nxt = 1'b0;
    else if (nxt == S_ALARM) mem_nxt = 1'b1;
  end

  // State, timer and outputs decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_DISARMED;
      cnt      <= '0;
      sirene   <= 1'b0;
      aviso    <= 1'b0;
      armado   <= 1'b0;
      memoria  <= 1'b0;
      arm_erro <= 1'b0;
    end else begin
      state    <= nxt;
      cnt      <= cnt_nxt;
      sirene   <= (nxt == S_ALARM);
      aviso    <= (nxt == S_EXIT) || (nxt == S_ENTRY);
      armado   <= (nxt != S_DISARMED);
      memoria  <= mem_nxt;
      arm_erro <= erro_nxt;
    end
  end

  assign estado = state;

endmodule
